reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the MIPS datapath. It generalises the 2-read/1-write file to NUM_RD combinational read ports and two write ports with defined collision priority. It adds a sequential clear engine that zeroes every register after reset or on request, and an optional write-to-read bypass. It sits between the decode stage (read ports) and the writeback stage (write ports), and keeps the debug read port used by the simulator front end.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
- NUM_RD, 2, number of read ports (1..8)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en0, wr_en1  in  1 each  write enables, port 0 / port 1
- w_addr0, w_addr1  in  ADDR_WIDTH each  write addresses
- w_data0, w_data1  in  DATA_WIDTH each  write data
- r_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- r_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing
- rdbg_addr  in  ADDR_WIDTH  debug read address
- rdbg_data  out  DATA_WIDTH  debug read data
- clr_req  in  1  one-cycle request to zero all registers
- clr_busy  out  1  clear engine active; writes are not accepted
- wr_drop  out  1  registered pulse: a write was discarded in the previous cycle

## Operation
- State machine with states CLEAR and READY.
- reset high: state goes to CLEAR, clear pointer goes to 0, wr_drop goes to 0.
- CLEAR:
  - Each cycle, regs[ptr] <= 0 and ptr increments.
  - When ptr == DEPTH-1, that register is cleared and the next state is READY.
  - ptr wraps to 0 on exit.
- READY, clr_req = 1: next state is CLEAR with ptr = 0.
- clr_req while in CLEAR: ignored; the clear is not restarted.
- Writes in READY:
  - wr_enN with w_addrN != 0 writes w_dataN on the clock edge.
  - Both ports enabled with the same address: port 1 wins and port 0's data is lost (this does not count as a drop).
- Writes in CLEAR: discarded. wr_drop = 1 in the following cycle if wr_en0 or wr_en1 was high and its address was nonzero.
- Writes to address 0 are discarded silently and do not assert wr_drop.
- Reads:
  - Combinational on every read port and the debug port.
  - Address 0 always returns 0.
  - While clr_busy = 1, every read port returns 0, including reads of not-yet-cleared registers.
- Bypass: see Configuration. The debug port never bypasses.

## Timing
- Reset values:
  - clr_busy = 1.
  - wr_drop = 0.
  - r_data and rdbg_data = 0 (forced by busy).
  - Register contents are undefined until the clear completes.
- clr_busy is a decode of state == CLEAR, so it is a registered output.
- Clear duration: after the last reset-high cycle, exactly DEPTH cycles with clr_busy = 1, then clr_busy = 0. The same applies after a clr_req edge.
- Reset asserted mid-clear: the clear restarts from ptr = 0 and lasts DEPTH full cycles after reset deasserts.
- Read latency is 0 cycles. A write at edge t is visible on the read ports after edge t.
- wr_drop latency is 1 cycle and the pulse lasts exactly one cycle per offending write cycle.
- clr_req and a write in the same READY cycle: the write is accepted (edge t). The clear starts at edge t+1, so the written register is overwritten when ptr reaches it.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - In READY, a read port whose address equals an enabled, nonzero write address in the same cycle returns that write data combinationally.
  - If both write ports match, port 1's data is returned.
  - Address 0 and CLEAR state still return 0.
- REG_FILE_BYPASS_EN undefined: read ports return stored contents only. A same-cycle write becomes visible after the edge.

## Test plan
- Reset 1 cycle, then idle -> clr_busy = 1 for exactly 32 cycles (defaults). Afterwards, all 32 registers read 0 on every port and on rdbg.
- After clear, write reg 5 = 0xDEADBEEF on port 0 and reg 6 = 0x12345678 on port 1 in the same cycle -> next cycle r_addr ports 0/1 = 5/6 return 0xDEADBEEF/0x12345678.
- Both ports write reg 9 (port 0 = 0x1, port 1 = 0x2) -> reg 9 reads 0x2. Write 0xFFFFFFFF to reg 0 -> reg 0 reads 0 and wr_drop stays 0.
- clr_req in READY with reg 5 = 0xDEADBEEF, plus a write to reg 7 at clear cycle 3 -> clr_busy high for 32 cycles, wr_drop pulses once a cycle later, and regs 5 and 7 read 0 afterwards.
- Reset asserted at clear cycle 10 -> clr_busy stays high for 32 cycles after reset deasserts.
- With REG_FILE_BYPASS_EN: write reg 3 = 0xA5A5A5A5 while r_addr port 1 = 3 -> same-cycle r_data port 1 = 0xA5A5A5A5 and rdbg_data(3) shows the old value. Without the macro, r_data port 1 shows the old value.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file (NUM_RD read ports, 2 write ports) with a sequential clear engine.
// Latency: reads are combinational (0 cycles); writes land on the rising edge; wr_drop is a 1-cycle-late pulse.
// Backpressure: while clr_busy is high, writes are discarded (flagged on wr_drop) and all read ports return 0.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset (starts a full clear)
//   wr_en0/1, w_addr0/1, w_data0/1 - two write ports; port 1 wins on an address collision
//   r_addr / r_data     - NUM_RD packed read ports, port k at [k*W +: W]
//   rdbg_addr/rdbg_data - debug read port (never bypassed)
//   clr_req             - one-cycle request to zero all registers (ignored while already clearing)
//   clr_busy            - clear engine active (decode of the state register)
//   wr_drop             - a nonzero-address write was discarded in the previous cycle
//
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.

module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en0,
    input  logic                         wr_en1,
    input  logic [ADDR_WIDTH-1:0]        w_addr0,
    input  logic [ADDR_WIDTH-1:0]        w_addr1,
    input  logic [DATA_WIDTH-1:0]        w_data0,
    input  logic [DATA_WIDTH-1:0]        w_data1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
    input  logic [ADDR_WIDTH-1:0]        rdbg_addr,
    output logic [DATA_WIDTH-1:0]        rdbg_data,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         wr_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic                    drop_nxt;
    logic                    busy;

    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    // Register 0 is hardwired to zero, so a write to it is neither stored nor reported as dropped.
    logic wr_ok0;
    logic wr_ok1;
    assign wr_ok0 = wr_en0 && (w_addr0 != '0);
    assign wr_ok1 = wr_en1 && (w_addr1 != '0);

    // ------------------------------------------------------------------
    // Clear engine state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            wr_drop <= drop_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        drop_nxt  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_CLEAR: begin
                busy     = 1'b1;
                drop_nxt = wr_ok0 || wr_ok1;
                // clr_req is deliberately not looked at here: a clear in progress is never restarted.
                if (ptr == PTR_LAST) begin
                    state_nxt = S_READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = busy;

    // ------------------------------------------------------------------
    // Storage. No reset: contents are defined by the clear engine.
    // Port 1 is assigned after port 0 so it wins an address collision.
    // A write in the same READY cycle as clr_req still lands; the clear
    // then overwrites it when ptr reaches that entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                regs[ptr] <= '0;
            end else begin
                if (wr_ok0) regs[w_addr0] <= w_data0;
                if (wr_ok1) regs[w_addr1] <= w_data1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = regs[ra];
`ifdef REG_FILE_BYPASS_EN
            // Port 1 is checked last so it takes precedence when both ports hit.
            if (wr_ok0 && (w_addr0 == ra)) rd = w_data0;
            if (wr_ok1 && (w_addr1 == ra)) rd = w_data1;
`endif
            // Busy masking also hides entries the clear has not reached yet.
            if (busy || (ra == '0)) rd = '0;
        end

        assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

    // Debug port shows committed contents only.
    assign rdbg_data = (busy || (rdbg_addr == '0)) ? '0 : regs[rdbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en0, wr_en1;
    logic [AW-1:0]     w_addr0, w_addr1;
    logic [DW-1:0]     w_data0, w_data1;
    logic [NR*AW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_data;
    logic [AW-1:0]     rdbg_addr;
    logic [DW-1:0]     rdbg_data;
    logic              clr_req;
    logic              clr_busy;
    logic              wr_drop;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en0    (wr_en0),
        .wr_en1    (wr_en1),
        .w_addr0   (w_addr0),
        .w_addr1   (w_addr1),
        .w_data0   (w_data0),
        .w_data1   (w_data1),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .rdbg_addr (rdbg_addr),
        .rdbg_data (rdbg_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .wr_drop   (wr_drop)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents plus a count of
    // remaining busy cycles. Contents are zeroed as soon as a clear begins,
    // which is indistinguishable externally because reads are masked while busy.
    logic [DW-1:0] mem [DEPTH];
    int            busy_left;
    logic          drop_exp;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit allow_byp);
        if (busy_left > 0 || a == 0) return '0;
        if (BYP && allow_byp) begin
            if (wr_en1 && w_addr1 == a) return w_data1;
            if (wr_en0 && w_addr0 == a) return w_data0;
        end
        return mem[a];
    endfunction

    task automatic check_outputs();
        logic [AW-1:0] a;
        chk("clr_busy", {31'b0, clr_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
        chk("wr_drop", {31'b0, wr_drop}, {31'b0, drop_exp});
        for (int k = 0; k < NR; k++) begin
            a = r_addr[k*AW +: AW];
            chk($sformatf("r_data%0d@%0d", k, a), r_data[k*DW +: DW], exp_read(a, 1'b1));
        end
        chk($sformatf("rdbg@%0d", rdbg_addr), rdbg_data, exp_read(rdbg_addr, 1'b0));
    endtask

    task automatic model_edge();
        if (reset) begin
            busy_left = DEPTH;
            drop_exp  = 1'b0;
        end else if (busy_left > 0) begin
            drop_exp  = (wr_en0 && w_addr0 != 0) || (wr_en1 && w_addr1 != 0);
            busy_left = busy_left - 1;
        end else begin
            drop_exp = 1'b0;
            if (wr_en0 && w_addr0 != 0) mem[w_addr0] = w_data0;
            if (wr_en1 && w_addr1 != 0) mem[w_addr1] = w_data1;
            if (clr_req) busy_left = DEPTH;
        end
        if (busy_left == DEPTH)
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // Check outputs for the current inputs, then advance one clock.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset   = 1'b0;
        clr_req = 1'b0;
        wr_en0  = 1'b0;
        wr_en1  = 1'b0;
        w_addr0 = AW'($urandom);
        w_addr1 = AW'($urandom);
        w_data0 = $urandom;
        w_data1 = $urandom;
        r_addr  = NR*AW'($urandom);
        rdbg_addr = AW'($urandom);
    endtask

    initial begin
        logic [AW-1:0] a;

        // Reset for one cycle.
        idle();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Clear window after reset, then every register reads 0 on all ports.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            a = AW'(i);
            r_addr    = {a ^ 5'd1, a};
            rdbg_addr = a;
            step();
        end

        // Two-port write in one cycle, read back next cycle.
        idle();
        wr_en0 = 1'b1; w_addr0 = 5'd5; w_data0 = 32'hDEADBEEF;
        wr_en1 = 1'b1; w_addr1 = 5'd6; w_data1 = 32'h12345678;
        step();
        idle();
        r_addr = {5'd6, 5'd5};
        #1;
        chk("rd5_direct", r_data[DW-1:0], 32'hDEADBEEF);
        chk("rd6_direct", r_data[2*DW-1:DW], 32'h12345678);
        step();

        // Collision: port 1 wins.
        idle();
        wr_en0 = 1'b1; w_addr0 = 5'd9; w_data0 = 32'h1;
        wr_en1 = 1'b1; w_addr1 = 5'd9; w_data1 = 32'h2;
        step();
        idle();
        r_addr = {5'd9, 5'd9};
        #1;
        chk("collision_rd9", r_data[DW-1:0], 32'h2);
        step();

        // Write to register 0 is silently ignored.
        idle();
        wr_en0 = 1'b1; w_addr0 = 5'd0; w_data0 = 32'hFFFFFFFF;
        step();
        idle();
        r_addr = {5'd0, 5'd0};
        rdbg_addr = 5'd0;
        step();

        // clr_req in READY; write during clear cycle 3; clr_req again mid-clear.
        idle();
        clr_req = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == 3) begin
                wr_en0 = 1'b1; w_addr0 = 5'd7; w_data0 = 32'hCAFEF00D;
            end
            if (i == 8) clr_req = 1'b1;
            step();
        end
        idle();
        r_addr = {5'd7, 5'd5};
        rdbg_addr = 5'd5;
        #1;
        chk("busy_done_after_req", {31'b0, clr_busy}, 32'd0);
        chk("rd5_cleared", r_data[DW-1:0], 32'd0);
        chk("rd7_cleared", r_data[2*DW-1:DW], 32'd0);
        step();

        // Reset at clear cycle 10 restarts the full clear.
        idle();
        clr_req = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            idle();
            step();
        end
        idle();
        reset = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            step();
        end

        // Bypass behaviour on a same-cycle write.
        idle();
        wr_en0 = 1'b1; w_addr0 = 5'd3; w_data0 = 32'h11111111;
        step();
        idle();
        wr_en0 = 1'b1; w_addr0 = 5'd3; w_data0 = 32'hA5A5A5A5;
        r_addr = {5'd3, 5'd4};
        rdbg_addr = 5'd3;
        #1;
        chk("bypass_port1", r_data[2*DW-1:DW], BYP ? 32'hA5A5A5A5 : 32'h11111111);
        chk("bypass_rdbg_old", rdbg_data, 32'h11111111);
        step();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            idle();
            wr_en0  = ($urandom_range(0, 2) != 0);
            wr_en1  = ($urandom_range(0, 2) != 0);
            w_addr0 = AW'($urandom_range(0, 7));
            w_addr1 = ($urandom_range(0, 3) == 0) ? w_addr0 : AW'($urandom_range(0, 7));
            r_addr  = {AW'($urandom_range(0, 7)),
                       ($urandom_range(0, 1) == 0) ? w_addr1 : AW'($urandom_range(0, 7))};
            rdbg_addr = AW'($urandom_range(0, 7));
            clr_req = ($urandom_range(0, 59) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
